// File: rtl/ct_had_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_had_pkg
// Purpose  : Shared constants and types for the HAD JTAG serial datapath.
//            Holds the IR codes, the DR length encodings, and the widths
//            used by the shifter and the register-file read mux.
// Ports    : none (package)
// Options  : HAD_SERIAL_PARITY_EN adds one even-parity bit to the MSB end
//            of every non-bypass DR chain.
// Revision : 1.0  initial release
// ============================================================================
package ct_had_pkg;

  localparam int IR_WIDTH     = 8;
  localparam int DR_MAX_WIDTH = 64;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE_VAL = 8'h01;
  localparam logic [IR_WIDTH-1:0] IR_BYPASS      = 8'hFF;

`ifdef HAD_SERIAL_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Physical width of the DR shift chain (data plus optional parity).
  localparam int DR_CHAIN_W = DR_MAX_WIDTH + PARITY_BITS;

  // Shift counter: wide enough for the longest chain, saturates at 127.
  localparam int               CNT_W   = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;

  typedef enum logic [1:0] {
    LEN_1  = 2'd0,
    LEN_32 = 2'd1,
    LEN_64 = 2'd2
  } dr_len_e;

  // Number of data bits selected by a length encoding.
  function automatic logic [CNT_W-1:0] dr_len_bits(input dr_len_e code);
    logic [CNT_W-1:0] bits;
    case (code)
      LEN_1:   bits = 7'd1;
      LEN_64:  bits = 7'd64;
      default: bits = 7'd32;
    endcase
    return bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ct_had_dr_len_dec.sv
`default_nettype none
// ============================================================================
// Module   : ct_had_dr_len_dec
// Purpose  : Combinational IR -> DR length decoder. Shared by the JTAG
//            shifter and the HAD register-file read mux so both agree on
//            which bits of a data register are live.
// Ports    : i_ir          committed instruction register
//            o_len_code    length encoding (LEN_1 / LEN_32 / LEN_64)
//            o_chain_len   total shift-chain length incl. optional parity
//            o_data_mask   ones on the live data bits
//            o_chain_mask  ones on every live chain bit (data + parity)
//            o_chain_msb   one-hot at chain bit (o_chain_len - 1)
// Options  : HAD_SERIAL_PARITY_EN (via ct_had_pkg::PARITY_BITS)
// Revision : 1.0  initial release
// ============================================================================
module ct_had_dr_len_dec
  import ct_had_pkg::*;
(
  input  logic [IR_WIDTH-1:0]     i_ir,
  output dr_len_e                 o_len_code,
  output logic [CNT_W-1:0]        o_chain_len,
  output logic [DR_MAX_WIDTH-1:0] o_data_mask,
  output logic [DR_CHAIN_W-1:0]   o_chain_mask,
  output logic [DR_CHAIN_W-1:0]   o_chain_msb
);

  logic [CNT_W-1:0] w_data_len;

  always_comb begin
    o_len_code = LEN_32;
    if (i_ir == IR_BYPASS) begin
      o_len_code = LEN_1;
    end else if (i_ir[6]) begin
      o_len_code = LEN_64;
    end
    w_data_len = dr_len_bits(o_len_code);
    // Bypass stays a plain 1-bit register; parity only extends real DRs.
    if (o_len_code == LEN_1) begin
      o_chain_len = w_data_len;
    end else begin
      o_chain_len = w_data_len + CNT_W'(PARITY_BITS);
    end
  end

  for (genvar gi = 0; gi < DR_MAX_WIDTH; gi++) begin : g_data_mask
    assign o_data_mask[gi] = (CNT_W'(gi) < w_data_len);
  end

  for (genvar gi = 0; gi < DR_CHAIN_W; gi++) begin : g_chain_mask
    assign o_chain_mask[gi] = (CNT_W'(gi) < o_chain_len);
    assign o_chain_msb[gi]  = (CNT_W'(gi) == (o_chain_len - CNT_W'(1)));
  end

endmodule
`default_nettype wire

// File: rtl/ct_had_jtag_shifter.sv
`default_nettype none
// ============================================================================
// Module   : ct_had_jtag_shifter
// Purpose  : Serial IR/DR datapath behind the HAD TAP controller. Shifts TDI
//            into an 8-bit IR and a length-decoded DR, drives TDO on the
//            falling edge, and presents committed IR/DR values plus a
//            toggle-style "DR updated" flag for a cpuclk synchroniser.
// Ports    : tclk, trst_b             JTAG clock, async active-low reset
//            pad_had_jtg_tdi          serial data in
//            sm_serial_shift_ir/dr    TAP in SHIFT_IR / SHIFT_DR
//            sm_serial_capture_dr     TAP in CAPTURE_DR
//            sm_update_ir/dr          TAP in UPDATE_IR / UPDATE_DR
//            regs_dr_capture_data     parallel read data for selected DR
//            shft_tdo                 serial data out (negedge registered)
//            shft_ir_value            committed IR
//            shft_dr_value            last committed DR
//            shft_dr_upd_tgl          toggles on each good DR update
//            shft_dr_len_err          last DR update was rejected
// Options  : HAD_SERIAL_PARITY_EN  appends an even-parity bit to DR chains
//            and requires it to match before an update commits.
// Revision : 1.0  initial release
// ============================================================================
module ct_had_jtag_shifter
  import ct_had_pkg::*;
(
  input  logic                    tclk,
  input  logic                    trst_b,
  input  logic                    pad_had_jtg_tdi,
  input  logic                    sm_serial_shift_ir,
  input  logic                    sm_serial_shift_dr,
  input  logic                    sm_serial_capture_dr,
  input  logic                    sm_update_ir,
  input  logic                    sm_update_dr,
  input  logic [DR_MAX_WIDTH-1:0] regs_dr_capture_data,
  output logic                    shft_tdo,
  output logic [IR_WIDTH-1:0]     shft_ir_value,
  output logic [DR_MAX_WIDTH-1:0] shft_dr_value,
  output logic                    shft_dr_upd_tgl,
  output logic                    shft_dr_len_err
);

  logic [IR_WIDTH-1:0]     r_ir_shift;
  logic [IR_WIDTH-1:0]     r_ir_value;
  logic [DR_CHAIN_W-1:0]   r_dr_shift;
  logic [DR_MAX_WIDTH-1:0] r_dr_value;
  logic [CNT_W-1:0]        r_shift_cnt;
  logic                    r_upd_tgl;
  logic                    r_len_err;
  logic                    r_tdo;

  dr_len_e                 w_len_code;
  logic [CNT_W-1:0]        w_chain_len;
  logic [DR_MAX_WIDTH-1:0] w_data_mask;
  logic [DR_CHAIN_W-1:0]   w_chain_mask;
  logic [DR_CHAIN_W-1:0]   w_chain_msb;

  logic                    w_is_bypass;
  logic                    w_do_capture;
  logic                    w_do_shift_dr;
  logic                    w_do_shift_ir;
  logic                    w_upd_gate;
  logic                    w_do_upd_ir;
  logic                    w_do_upd_dr;
  logic [DR_MAX_WIDTH-1:0] w_cap_data;
  logic [DR_CHAIN_W-1:0]   w_cap_chain;
  logic [DR_CHAIN_W-1:0]   w_dr_shifted;
  logic [DR_MAX_WIDTH-1:0] w_commit_val;
  logic                    w_len_ok;
  logic                    w_parity_ok;

  // Length is decoded from the committed IR, which only moves in UPDATE_IR,
  // so it is stable for the whole capture/shift/update of a DR scan.
  ct_had_dr_len_dec u_len_dec (
    .i_ir         (r_ir_value),
    .o_len_code   (w_len_code),
    .o_chain_len  (w_chain_len),
    .o_data_mask  (w_data_mask),
    .o_chain_mask (w_chain_mask),
    .o_chain_msb  (w_chain_msb)
  );

  assign w_is_bypass = (w_len_code == LEN_1);

  // Strobes are mutually exclusive from a healthy TAP; if several arrive
  // anyway, capture_dr > shift_dr > shift_ir > update.
  assign w_do_capture  = sm_serial_capture_dr;
  assign w_do_shift_dr = sm_serial_shift_dr & ~sm_serial_capture_dr;
  assign w_do_shift_ir = sm_serial_shift_ir & ~sm_serial_shift_dr & ~sm_serial_capture_dr;
  assign w_upd_gate    = ~(sm_serial_capture_dr | sm_serial_shift_dr | sm_serial_shift_ir);
  assign w_do_upd_ir   = sm_update_ir & w_upd_gate;
  assign w_do_upd_dr   = sm_update_dr & w_upd_gate;

  assign w_cap_data   = regs_dr_capture_data & w_data_mask;
  assign w_commit_val = r_dr_shift[DR_MAX_WIDTH-1:0] & w_data_mask;
  assign w_len_ok     = (r_shift_cnt == w_chain_len);

  // TDI enters at the top of the live chain; everything above stays zero.
  assign w_dr_shifted = ((r_dr_shift >> 1) & w_chain_mask)
                      | ({DR_CHAIN_W{pad_had_jtg_tdi}} & w_chain_msb);

`ifdef HAD_SERIAL_PARITY_EN
  logic w_cap_parity;
  // Even parity over the captured data rides in the chain MSB so the
  // debugger can validate reads; writes must carry a matching bit.
  assign w_cap_parity = ^w_cap_data;
  assign w_cap_chain  = w_is_bypass ? '0
                      : (DR_CHAIN_W'(w_cap_data) | ({DR_CHAIN_W{w_cap_parity}} & w_chain_msb));
  assign w_parity_ok  = ((^w_commit_val) == (|(r_dr_shift & w_chain_msb)));
`else
  assign w_cap_chain  = w_is_bypass ? '0 : w_cap_data;
  assign w_parity_ok  = 1'b1;
`endif

  // Instruction register path.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_ir_shift <= IR_CAPTURE_VAL;
      r_ir_value <= IR_BYPASS;
    end else if (w_do_shift_ir) begin
      r_ir_shift <= {pad_had_jtg_tdi, r_ir_shift[IR_WIDTH-1:1]};
    end else if (w_do_upd_ir) begin
      r_ir_value <= r_ir_shift;
      r_ir_shift <= IR_CAPTURE_VAL;
    end
  end

  // Data register path. The counter is untouched outside capture/shift so
  // a PAUSE/EXIT2 detour keeps counting where it left off.
  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_dr_shift  <= '0;
      r_dr_value  <= '0;
      r_shift_cnt <= '0;
      r_upd_tgl   <= 1'b0;
      r_len_err   <= 1'b0;
    end else if (w_do_capture) begin
      r_dr_shift  <= w_cap_chain;
      r_shift_cnt <= '0;
    end else if (w_do_shift_dr) begin
      r_dr_shift <= w_dr_shifted;
      if (r_shift_cnt != CNT_MAX) begin
        r_shift_cnt <= r_shift_cnt + CNT_W'(1);
      end
    end else if (w_do_upd_dr && !w_is_bypass) begin
      if (w_len_ok && w_parity_ok) begin
        r_dr_value <= w_commit_val;
        r_upd_tgl  <= ~r_upd_tgl;
        r_len_err  <= 1'b0;
      end else begin
        r_len_err  <= 1'b1;
      end
    end
  end

  // TDO launches on the falling edge so the probe samples it mid-bit.
  always_ff @(negedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      r_tdo <= 1'b0;
    end else if (w_do_shift_dr) begin
      r_tdo <= r_dr_shift[0];
    end else if (w_do_shift_ir) begin
      r_tdo <= r_ir_shift[0];
    end else begin
      r_tdo <= 1'b0;
    end
  end

  assign shft_tdo        = r_tdo;
  assign shft_ir_value   = r_ir_value;
  assign shft_dr_value   = r_dr_value;
  assign shft_dr_upd_tgl = r_upd_tgl;
  assign shft_dr_len_err = r_len_err;

endmodule
`default_nettype wire

// File: doc/ct_had_jtag_shifter.md
Name: ct_had_jtag_shifter

Overview:
- Serial datapath stage directly downstream of the HAD TAP5 controller.
- Consumes the tclk-domain shift_ir, shift_dr, capture_dr and update strobes, and shifts TDI into an 8-bit IR and a variable-length DR.
- Drives TDO and presents the parallel IR/DR contents to the HAD register file.
- Gives the cpuclk side a toggle-based "DR updated" indication that a 3-flop synchroniser can safely carry.

Parameters:
- IR_WIDTH, 8, instruction register width (fixed at 8 in this design).
- DR_MAX_WIDTH, 64, widest data register.
- IR_CAPTURE_VAL, 8'h01, value loaded into the IR shift chain at reset and after every IR update.
- IR_BYPASS, 8'hFF, IR code selecting the 1-bit bypass DR.

Ports:
- tclk  in  1  JTAG clock.
- trst_b  in  1  JTAG reset.
- pad_had_jtg_tdi  in  1  serial data in.
- sm_serial_shift_ir  in  1  TAP in SHIFT_IR.
- sm_serial_shift_dr  in  1  TAP in SHIFT_DR.
- sm_serial_capture_dr  in  1  TAP in CAPTURE_DR.
- sm_update_ir  in  1  TAP in UPDATE_IR (level, one tclk per visit).
- sm_update_dr  in  1  TAP in UPDATE_DR.
- regs_dr_capture_data  in  64  parallel read data for the selected DR.
- shft_tdo  out  1  serial data out.
- shft_ir_value  out  8  current committed IR.
- shft_dr_value  out  64  last committed DR.
- shft_dr_upd_tgl  out  1  toggles on each good DR update.
- shft_dr_len_err  out  1  sticky: last DR update had the wrong shift count.

Interface note: reset is trst_b, asynchronous, active-low; clock is tclk.

Behaviour:
- Reset values (trst_b low):
  - ir_shift = IR_CAPTURE_VAL; shft_ir_value = IR_BYPASS.
  - dr_shift = 0; shft_dr_value = 0.
  - shft_tdo = 0; shft_dr_upd_tgl = 0; shft_dr_len_err = 0; shift counter = 0.
- DR length decode from shft_ir_value:
  - 8'hFF → 1 bit.
  - ir[6] = 1 → 64 bits.
  - otherwise → 32 bits.
  - Length is fixed while in the DR path because the IR only changes in UPDATE_IR.
- IR shift (posedge, shift_ir = 1): ir_shift <= {tdi, ir_shift[7:1]}, LSB first.
- IR update (posedge, sm_update_ir = 1): shft_ir_value <= ir_shift, and ir_shift reloads IR_CAPTURE_VAL in the same cycle.
- DR capture (posedge, capture_dr = 1): dr_shift <= regs_dr_capture_data masked to the decoded length; bypass loads 0. Shift counter clears to 0.
- DR shift (posedge, shift_dr = 1):
  - Shift right within the decoded length; tdi enters bit len-1. Bits at len and above hold 0.
  - Counter increments and saturates at 127.
- DR update (posedge, sm_update_dr = 1):
  - Count == length: shft_dr_value <= dr_shift (zero-extended), shft_dr_upd_tgl inverts, shft_dr_len_err <= 0.
  - Otherwise: shft_dr_value holds, no toggle, shft_dr_len_err <= 1.
  - Bypass updates never toggle and never set the error.
- TDO: registered on negedge tclk.
  - shift_ir: ir_shift[0].
  - shift_dr: dr_shift[0].
  - else: 0.
  - First shifted-out bit therefore appears half a cycle after the TAP enters SHIFT.
- Pause/Exit states: all shift state holds; the counter continues across PAUSE→EXIT2→SHIFT re-entry.
- Simultaneous strobes are impossible (states are mutually exclusive). If presented anyway, priority is capture_dr > shift_dr > shift_ir > update.
- trst_b assert mid-shift: everything returns to reset values at once. A partial DR never commits and the toggle does not move.

Optional Feature:
- Macro: HAD_SERIAL_PARITY_EN.
- Defined:
  - DR length grows by one extra parity bit, shifted last (MSB).
  - Update commits only if the count equals length+1 and the XOR of the data bits equals the parity bit; otherwise shft_dr_len_err <= 1.
  - Capture appends the even parity of the capture data so the debugger can check reads.
- Undefined: no parity bit; behaviour is as above.

Decomposition:
- Shared package ct_had_pkg holds:
  - IR code constants: IR_BYPASS, IR_CAPTURE_VAL.
  - DR length encodings: LEN_1, LEN_32, LEN_64.
  - IR_WIDTH and DR_MAX_WIDTH.
- One natural sub-module: ct_had_dr_len_dec, a combinational IR → length/mask decoder reused by the register-file read mux.

Test Plan:
- IR write: shift 8'h8A LSB first then UPDATE_IR → shft_ir_value = 8'h8A. TDO over those 8 shifts = 1,0,0,0,0,0,0,0 (capture value 8'h01).
- 32-bit DR: IR = 8'h02, capture 64'h0000_0000_DEAD_BEEF, shift 32 bits of 32'h1234_5678 → TDO streams EF,BE,AD,DE LSB first; shft_dr_value = 64'h1234_5678; toggle flips once.
- 64-bit DR with one PAUSE_DR after bit 20 → shft_dr_value equals the full 64-bit pattern; no error.
- Short shift: 64-bit IR, only 63 shifts then UPDATE_DR → shft_dr_len_err = 1; shft_dr_value and toggle unchanged.
- Bypass: IR = 8'hFF, shift 4 bits 1,0,1,1 → TDO = 0,1,0,1 (one-bit delay); no toggle.
- trst_b pulsed at shift bit 10 → all outputs at reset values; the next full sequence succeeds.
